// File: rtl/tlc_pkg.sv
// Shared types and default timing for the pedestrian request path and the
// traffic light controller it feeds.
package tlc_pkg;

  // Request FSM states; encoding is shared with traffic_light_controller.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } tlc_state_e;

  // Default timing at a 100 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;    // 10 ms
  localparam int DEF_EN_HOLD_CYCLES  = 50000000;   // 0.5 s
  localparam int DEF_COOLDOWN_CYCLES = 100000000;  // 1 s

  // Largest of three values, used to size a shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: two-flop synchroniser, stability-count debounce and
// rising-edge detect on the debounced level.
module btn_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             db_d;
  logic [CNT_W-1:0] db_cnt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed with db for a full run;
  // any agreement in between restarts the count, discarding bounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 != db) begin
      if (db_cnt == CNT_LAST) begin
        db     <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Delayed copy of db for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_d <= 1'b0;
    else        db_d <= db;
  end

  // Only the press (rising) edge is of interest; releases are ignored.
  assign press = db & ~db_d;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: turns debounced button presses into
// fixed-length enable windows separated by a cooldown, remembers one press
// made during cooldown, and offers an auto mode that forces the enable high.
module ped_request_ctrl
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EN_HOLD_CYCLES  = DEF_EN_HOLD_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic CLK_I,
  input  logic RST_N_I,
  input  logic BTN_I,
  input  logic MODE_AUTO_I,
  output logic EN_O,
  output logic BTN_DB_O,
  output logic PENDING_O,
  output logic BUSY_O
);

  localparam int               TMR_W     = $clog2(max3(DEBOUNCE_CYCLES, EN_HOLD_CYCLES,
                                                       COOLDOWN_CYCLES));
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(EN_HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LAST = TMR_W'(COOLDOWN_CYCLES - 1);

  tlc_state_e       state;
  tlc_state_e       state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             pending;
  logic             pending_nxt;
  logic             db;
  logic             press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (CLK_I),
    .rst_n  (RST_N_I),
    .btn_raw(BTN_I),
    .db     (db),
    .press  (press)
  );

  // State, shared timer and queued-press flag.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state   <= IDLE;
      tmr     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      pending <= pending_nxt;
    end
  end

  // Window / cooldown sequencing. Presses during ACTIVE are already being
  // served; presses during COOLDOWN collapse into a single pending request.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr + 1'b1;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (press) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (tmr == HOLD_LAST) begin
          state_nxt = COOLDOWN;
          tmr_nxt   = '0;
        end
      end
      COOLDOWN: begin
        if (tmr == COOL_LAST) begin
          tmr_nxt     = '0;
          pending_nxt = 1'b0;
          state_nxt   = (pending || press) ? ACTIVE : IDLE;
        end else if (press) begin
          pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        tmr_nxt     = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state only; auto mode overrides EN_O.
  always_comb begin
    EN_O      = (state == ACTIVE) | MODE_AUTO_I;
    BUSY_O    = (state != IDLE);
    PENDING_O = pending;
    BTN_DB_O  = db;
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: directed scenarios plus randomized button,
// bounce, auto-mode and reset activity, all compared every cycle against a
// behavioural model of the request rules.
module tb_ped_request_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int COOL = 6;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic btn    = 1'b0;
  logic auto_m = 1'b0;
  logic en, db, pend, busy;

  always #5 clk = ~clk;

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .EN_HOLD_CYCLES (HOLD),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .CLK_I      (clk),
    .RST_N_I    (rst_n),
    .BTN_I      (btn),
    .MODE_AUTO_I(auto_m),
    .EN_O       (en),
    .BTN_DB_O   (db),
    .PENDING_O  (pend),
    .BUSY_O     (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: raw button seen two samples late; the debounced level
  // flips once the last DB samples all disagree with it; a window is a
  // countdown of HOLD cycles, then COOL cycles of cooldown.
  bit s1, s2, mdb, mdbd, mpend;
  bit hist[$];
  int ph;    // 0 idle, 1 enable window, 2 cooldown
  int left;  // cycles remaining in the current phase

  task automatic model_reset();
    s1 = 0; s2 = 0; mdb = 0; mdbd = 0; mpend = 0;
    hist.delete();
    ph = 0; left = 0;
  endtask

  task automatic model_edge();
    bit p, all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    p = mdb & ~mdbd;
    case (ph)
      0: if (p) begin ph = 1; left = HOLD; end
      1: begin
        left--;
        if (left == 0) begin ph = 2; left = COOL; end
      end
      default: begin
        if (p) mpend = 1;
        left--;
        if (left == 0) begin
          if (mpend) begin ph = 1; left = HOLD; mpend = 0; end
          else ph = 0;
        end
      end
    endcase
    mdbd = mdb;
    hist.push_back(s2);
    if (hist.size() > DB) void'(hist.pop_front());
    all_diff = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] == mdb) all_diff = 0;
    if (all_diff) mdb = ~mdb;
    s2 = s1;
    s1 = btn;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".en"},   en,   (ph == 1) | auto_m);
    chk({tag, ".db"},   db,   mdb);
    chk({tag, ".pend"}, pend, mpend);
    chk({tag, ".busy"}, busy, ph != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
  endtask

  // Observation counters for directed scenarios.
  int  o_edge, o_db_rise, o_en_rise, o_en_cnt, o_busy_cnt, o_db_cnt, o_pend_cnt, o_pulses;
  logic o_en_prev;

  task automatic obs_clear();
    o_edge = 0; o_db_rise = -1; o_en_rise = -1; o_en_cnt = 0; o_busy_cnt = 0;
    o_db_cnt = 0; o_pend_cnt = 0; o_pulses = 0; o_en_prev = en;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      o_edge++;
      if (db && o_db_rise < 0) o_db_rise = o_edge;
      if (en && !o_en_prev) begin
        o_pulses++;
        if (o_en_rise < 0) o_en_rise = o_edge;
      end
      o_en_prev = en;
      o_en_cnt   += int'(en);
      o_busy_cnt += int'(busy);
      o_db_cnt   += int'(db);
      o_pend_cnt += int'(pend);
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // 1: reset with button held, then the first window after release
    rst_n = 0; btn = 1; auto_m = 0;
    repeat (5) step();
    rst_n = 1;
    obs_clear();
    observe(25);
    chk("s1.db_rise", o_db_rise, DB + 2);
    chk("s1.en_rise", o_en_rise, DB + 3);
    chk("s1.en_cnt", o_en_cnt, HOLD);
    chk("s1.busy_cnt", o_busy_cnt, HOLD + COOL);

    // 2: clean press from idle, release produces nothing
    btn = 0; observe(30);
    obs_clear();
    btn = 1; observe(20);
    chk("s2.en_rise", o_en_rise, DB + 3);
    chk("s2.pulses", o_pulses, 1);
    chk("s2.en_cnt", o_en_cnt, HOLD);
    obs_clear();
    btn = 0; observe(25);
    chk("s2.release_en", o_en_cnt, 0);

    // 3: bouncy press, then an isolated short glitch
    obs_clear();
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0);
      observe(2);
    end
    chk("s3.bounce_db", o_db_cnt, 0);
    btn = 1; observe(30);
    chk("s3.db_rise", o_db_rise, 12 + DB + 2);
    chk("s3.en_rise", o_en_rise, 12 + DB + 3);
    chk("s3.pulses", o_pulses, 1);
    btn = 0; observe(30);
    obs_clear();
    btn = 1; observe(3);
    btn = 0; observe(12);
    chk("s3.glitch_db", o_db_cnt, 0);
    chk("s3.glitch_en", o_en_cnt, 0);

    // 4a: second press lands on the last ACTIVE cycle and is ignored
    obs_clear();
    btn = 1; observe(4);
    btn = 0; observe(4);
    btn = 1; observe(20);
    btn = 0; observe(30);
    chk("s4.active_pulses", o_pulses, 1);
    chk("s4.active_pend", o_pend_cnt, 0);

    // 4b: press during cooldown queues exactly one extra window
    obs_clear();
    btn = 1; observe(4);
    btn = 0; observe(6);
    btn = 1; observe(10);
    btn = 0; observe(30);
    chk("s4.cool_pulses", o_pulses, 2);
    chk("s4.cool_en_cnt", o_en_cnt, 2 * HOLD);
    chk("s4.cool_pend_cnt", o_pend_cnt, 4);
    chk("s4.cool_busy_cnt", o_busy_cnt, 2 * HOLD + 2 * COOL);

    // 5: auto mode forces EN_O while the FSM keeps running
    auto_m = 1;
    #1;
    chk("s5.en_imm", en, 1);
    chk("s5.busy_imm", busy, 0);
    obs_clear();
    btn = 1; observe(4);
    btn = 0; observe(26);
    chk("s5.busy_cnt", o_busy_cnt, HOLD + COOL);
    chk("s5.en_cnt", o_en_cnt, 30);
    btn = 1; observe(4);
    btn = 0; observe(13);
    auto_m = 0;
    #1;
    chk("s5.en_drop", en, 0);
    chk("s5.busy_cool", busy, 1);
    observe(20);

    // 6a: reset during ACTIVE cancels the window
    obs_clear();
    btn = 1; observe(4);
    btn = 0; observe(5);
    chk("s6.en_before", en, 1);
    async_reset("s6.rst_active");
    chk("s6.en_rst", en, 0);
    chk("s6.busy_rst", busy, 0);
    obs_clear();
    observe(20);
    chk("s6.idle_busy", o_busy_cnt, 0);
    chk("s6.idle_en", o_en_cnt, 0);

    // 6b: reset during cooldown drops the pending press
    btn = 1; observe(4);
    btn = 0; observe(6);
    btn = 1; observe(8);
    chk("s6.pend_before", pend, 1);
    btn = 0;
    async_reset("s6.rst_cool");
    chk("s6.pend_rst", pend, 0);
    obs_clear();
    observe(20);
    chk("s6.cool_idle_busy", o_busy_cnt, 0);

    // Randomized activity against the model
    for (int seg = 0; seg < 400; seg++) begin
      int kind;
      kind = $urandom_range(0, 39);
      if (kind == 0) begin
        async_reset("rnd.rst");
      end else if (kind < 5) begin
        auto_m = ~auto_m;
        #1;
        compare_all("rnd.auto");
      end else if (kind < 12) begin
        int n;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
          btn = ~btn;
          step();
        end
      end else begin
        btn = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 20)) step();
      end
    end
    auto_m = 0;
    btn = 0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
